// File: rtl/ddr3_adapter_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_adapter_pkg
// Shared definitions for the 32-bit word to 128-bit line adapter that sits in
// front of ddr3_core: the controller state encoding, the address field
// layout of a 16-byte line and a helper that places a word's byte enables
// into the 16-bit line byte mask.
// ---------------------------------------------------------------------------
package ddr3_adapter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH_REQ,
      ST_FLUSH_ACK,
      ST_RD_REQ,
      ST_RD_ACK,
      ST_RESP
   } adapter_state_t;

   localparam int LINE_BYTES = 16;
   localparam int LINE_BITS  = 8 * LINE_BYTES;
   localparam int WORD_LSB   = 2;
   localparam int WORD_MSB   = 3;
   localparam int LINE_LSB   = 4;
   localparam int LINE_MSB   = 31;
   localparam int LINE_W     = LINE_MSB - LINE_LSB + 1;

   // Byte enables of word 'word' moved to their lanes in the line mask.
   function automatic logic [LINE_BYTES-1:0] lane_mask(input logic [1:0] word,
                                                        input logic [3:0] be);
      logic [LINE_BYTES-1:0] m;
      m = '0;
      m[4*word +: 4] = be;
      return m;
   endfunction

endpackage

// File: rtl/ddr3_word_adapter_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces of ddr3_word_adapter.
//   ddr3_req_if    : upstream 32-bit word request / read response channel.
//                    master = requester, slave = adapter.
//                    (req_valid/req_we/req_addr/req_wdata/req_be -> adapter,
//                     req_ready/resp_valid/resp_rdata/resp_error <- adapter)
//   ddr3_inport_if : 128-bit line channel toward ddr3_core's inport.
//                    master = adapter, slave = core.
//                    (wr/rd/addr/write_data/req_id -> core,
//                     accept/ack/error/resp_id/read_data <- core)
// ---------------------------------------------------------------------------
interface ddr3_req_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                   input  req_ready, resp_valid, resp_rdata, resp_error);
   modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be,
                   output req_ready, resp_valid, resp_rdata, resp_error);
endinterface

interface ddr3_inport_if;
   import ddr3_adapter_pkg::*;

   logic [LINE_BYTES-1:0] wr;
   logic                  rd;
   logic [31:0]           addr;
   logic [LINE_BITS-1:0]  write_data;
   logic [15:0]           req_id;
   logic                  accept;
   logic                  ack;
   logic                  error;
   logic [15:0]           resp_id;
   logic [LINE_BITS-1:0]  read_data;

   modport master (output wr, rd, addr, write_data, req_id,
                   input  accept, ack, error, resp_id, read_data);
   modport slave  (input  wr, rd, addr, write_data, req_id,
                   output accept, ack, error, resp_id, read_data);
endinterface

// File: rtl/ddr3_wr_merge_buf.sv
// ---------------------------------------------------------------------------
// ddr3_wr_merge_buf
// One-line posted-write buffer. Merges word writes into a 16-byte line
// (data + byte mask), tracks the line tag and counts idle cycles so a
// partially filled line can be flushed after FLUSH_TIMEOUT cycles.
//   clk_i, rst_ni      clock, async active-low reset
//   merge, merge_*     write one word into the line (sets tag, ORs mask)
//   clear              drop the line after it has been handed to the core
//   tick               one more idle cycle with the buffer valid
//   valid/line/data/mask  buffer contents
//   timeout_hit        idle count has reached FLUSH_TIMEOUT-1
// ---------------------------------------------------------------------------
module ddr3_wr_merge_buf
   import ddr3_adapter_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  merge,
   input  logic [LINE_W-1:0]     merge_line,
   input  logic [1:0]            merge_word,
   input  logic [31:0]           merge_wdata,
   input  logic [3:0]            merge_be,
   input  logic                  clear,
   input  logic                  tick,
   output logic                  valid,
   output logic [LINE_W-1:0]     line,
   output logic [LINE_BITS-1:0]  data,
   output logic [LINE_BYTES-1:0] mask,
   output logic                  timeout_hit
);

   // The counter never needs to exceed FLUSH_TIMEOUT-1: the flush starts then.
   localparam int CNT_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

   logic [CNT_W-1:0]      cnt;
   logic [LINE_BYTES-1:0] new_bytes;

   assign new_bytes   = lane_mask(merge_word, merge_be);
   assign timeout_hit = (FLUSH_TIMEOUT != 0) && valid && (int'(cnt) == FLUSH_TIMEOUT - 1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid <= 1'b0;
         line  <= '0;
         data  <= '0;
         mask  <= '0;
         cnt   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         line  <= '0;
         data  <= '0;
         mask  <= '0;
         cnt   <= '0;
      end else if (merge) begin
         valid <= 1'b1;
         line  <= merge_line;
         mask  <= mask | new_bytes;
         cnt   <= '0;
         for (int i = 0; i < LINE_BYTES; i++) begin
            if (new_bytes[i]) data[8*i +: 8] <= merge_wdata[8*(i%4) +: 8];
         end
      end else if (tick) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ddr3_word_adapter.sv
// ---------------------------------------------------------------------------
// ddr3_word_adapter
// Converts 32-bit word requests into 128-bit line transactions for ddr3_core.
// Writes are posted into a one-line merge buffer; reads flush the buffer
// first and then fetch the whole line, returning the addressed word. Only
// one core transaction is in flight at a time.
//   clk_i, rst_ni  clock, async active-low reset
//   req            upstream word request / read response (slave side)
//   inport         core line channel (master side)
//   flush_i        force out a partially filled write line
//   idle_o         nothing buffered, nothing in flight
//   wr_err_o       sticky: a line write came back with error or wrong ID
// ---------------------------------------------------------------------------
module ddr3_word_adapter
   import ddr3_adapter_pkg::*;
#(
   parameter int          FLUSH_TIMEOUT = 64,
   parameter logic [15:0] ID_BASE       = 16'h0000
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   ddr3_req_if.slave     req,
   ddr3_inport_if.master inport,
   input  logic          flush_i,
   output logic          idle_o,
   output logic          wr_err_o
);

   adapter_state_t        state, state_nxt;
   logic [15:0]           id;
   logic [LINE_W-1:0]     rd_line;
   logic [1:0]            rd_word;
   logic [31:0]           rdata_q;
   logic                  rerr_q;
   logic                  wr_err;
   logic                  ready_en;

   logic [LINE_W-1:0]     req_line;
   logic [1:0]            req_word;
   logic                  buf_valid;
   logic [LINE_W-1:0]     buf_line;
   logic [LINE_BITS-1:0]  buf_data;
   logic [LINE_BYTES-1:0] buf_mask;
   logic                  timeout_hit;
   logic                  line_hit, flush_cond, id_miss, ready;
   logic                  wr_acc, rd_acc, buf_clear, buf_tick, id_inc, rd_cap, wr_ack_bad;
   logic                  unused_addr;

   assign req_line    = req.req_addr[LINE_MSB:LINE_LSB];
   assign req_word    = req.req_addr[WORD_MSB:WORD_LSB];
   assign unused_addr = ^req.req_addr[WORD_LSB-1:0];
   assign line_hit    = (buf_line == req_line);

   // The buffer must go out before anything else can happen: it is full,
   // timed out, forced, or blocks a read / a write to another line.
   assign flush_cond = buf_valid && ((&buf_mask) || timeout_hit || flush_i ||
                       (req.req_valid && (!req.req_we || !line_hit)));

   // The ID was bumped on accept, so the outstanding request carries id-1.
   assign id_miss = (inport.resp_id != (id - 16'd1));

   ddr3_wr_merge_buf #(
      .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
   ) u_buf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .merge       (wr_acc),
      .merge_line  (req_line),
      .merge_word  (req_word),
      .merge_wdata (req.req_wdata),
      .merge_be    (req.req_be),
      .clear       (buf_clear),
      .tick        (buf_tick),
      .valid       (buf_valid),
      .line        (buf_line),
      .data        (buf_data),
      .mask        (buf_mask),
      .timeout_hit (timeout_hit)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ST_IDLE;
         id       <= ID_BASE;
         rd_line  <= '0;
         rd_word  <= '0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         wr_err   <= 1'b0;
         ready_en <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
         if (id_inc) id <= id + 16'd1;
         if (rd_acc) begin
            rd_line <= req_line;
            rd_word <= req_word;
         end
         if (rd_cap) begin
            rdata_q <= inport.read_data[{rd_word, 5'd0} +: 32];
            rerr_q  <= inport.error || id_miss;
         end
         if (wr_ack_bad) wr_err <= 1'b1;
      end
   end

   always_comb begin
      state_nxt         = state;
      ready             = 1'b0;
      wr_acc            = 1'b0;
      rd_acc            = 1'b0;
      buf_clear         = 1'b0;
      buf_tick          = 1'b0;
      id_inc            = 1'b0;
      rd_cap            = 1'b0;
      wr_ack_bad        = 1'b0;
      req.resp_valid    = 1'b0;
      req.resp_error    = 1'b0;
      inport.wr         = '0;
      inport.rd         = 1'b0;
      inport.addr       = '0;
      inport.write_data = '0;
      unique case (state)
         ST_IDLE: begin
            if (flush_cond) begin
               state_nxt = ST_FLUSH_REQ;
            end else if (ready_en) begin
               ready  = req.req_we ? (!buf_valid || line_hit) : !buf_valid;
               wr_acc = req.req_valid && req.req_we && ready;
               rd_acc = req.req_valid && !req.req_we && ready;
               if (rd_acc) state_nxt = ST_RD_REQ;
            end
            buf_tick = buf_valid && !wr_acc;
         end
         ST_FLUSH_REQ: begin
            inport.wr         = buf_mask;
            inport.addr       = {buf_line, 4'b0000};
            inport.write_data = buf_data;
            if (inport.accept) begin
               buf_clear = 1'b1;
               id_inc    = 1'b1;
               state_nxt = ST_FLUSH_ACK;
            end
         end
         ST_FLUSH_ACK: begin
            if (inport.ack) begin
               wr_ack_bad = inport.error || id_miss;
               state_nxt  = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            inport.rd   = 1'b1;
            inport.addr = {rd_line, 4'b0000};
            if (inport.accept) begin
               id_inc    = 1'b1;
               state_nxt = ST_RD_ACK;
            end
         end
         ST_RD_ACK: begin
            if (inport.ack) begin
               rd_cap    = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            req.resp_valid = 1'b1;
            req.resp_error = rerr_q;
            state_nxt      = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign req.req_ready  = ready;
   assign req.resp_rdata = rdata_q;
   assign inport.req_id  = id;
   assign idle_o         = (state == ST_IDLE) && !buf_valid;
   assign wr_err_o       = wr_err;

endmodule

// File: tb/tb_ddr3_word_adapter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_word_adapter
// Directed bench for ddr3_word_adapter: a table of single write/flush and
// read transactions plus hand-written sequences for timeout, full-line merge,
// line change, read-after-write ordering, error reporting, byte merging and
// reset in the middle of a read. The bench plays the role of ddr3_core.
// ---------------------------------------------------------------------------
module tb_ddr3_word_adapter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic idle;
   logic wr_err;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] exp_id = 16'h0000;

   ddr3_req_if    req_bus ();
   ddr3_inport_if core_bus ();

   ddr3_word_adapter #(
      .FLUSH_TIMEOUT(64),
      .ID_BASE      (16'h0000)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req      (req_bus),
      .inport   (core_bus),
      .flush_i  (flush),
      .idle_o   (idle),
      .wr_err_o (wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      logic [3:0]   be;
      logic [15:0]  exp_mask;
      logic [31:0]  exp_addr;
      logic [127:0] line;       // write: expected line data; read: line returned by core
      logic [31:0]  exp_rdata;
   } vec_t;

   localparam int NVEC = 7;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " idle"},       idle, 1'b1);
      check({tag, " req_id"},     core_bus.req_id, 16'h0000);
      check({tag, " wr"},         core_bus.wr, 16'h0000);
      check({tag, " rd"},         core_bus.rd, 1'b0);
      check({tag, " addr"},       core_bus.addr, 32'h0);
      check({tag, " wdata"},      core_bus.write_data, 128'h0);
      check({tag, " ready"},      req_bus.req_ready, 1'b0);
      check({tag, " resp_valid"}, req_bus.resp_valid, 1'b0);
      check({tag, " resp_err"},   req_bus.resp_error, 1'b0);
      check({tag, " rdata"},      req_bus.resp_rdata, 32'h0);
      check({tag, " wr_err"},     wr_err, 1'b0);
   endtask

   task automatic req_start(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
      req_bus.req_valid = 1'b1;
      req_bus.req_we    = we;
      req_bus.req_addr  = addr;
      req_bus.req_wdata = wdata;
      req_bus.req_be    = be;
   endtask

   // Holds the request until the adapter takes it (bounded), returns on the
   // falling edge after the accepting rising edge.
   task automatic req_wait_accept(input string name);
      int n = 0;
      #1;
      while (!req_bus.req_ready && n < 300) begin
         @(negedge clk); #1; n++;
      end
      check({name, " accepted"}, req_bus.req_ready, 1'b1);
      @(negedge clk);
      req_bus.req_valid = 1'b0;
   endtask

   task automatic core_write_txn(input string name, input logic [15:0] exp_mask,
                                 input logic [31:0] exp_addr, input logic [127:0] exp_data,
                                 input logic err, input logic [15:0] id_off);
      int n = 0;
      #1;
      while (core_bus.wr == 16'h0 && n < 300) begin
         @(negedge clk); #1; n++;
      end
      check({name, " wr mask"}, core_bus.wr, exp_mask);
      check({name, " wr addr"}, core_bus.addr, exp_addr);
      check({name, " wr data"}, core_bus.write_data, exp_data);
      check({name, " wr id"},   core_bus.req_id, exp_id);
      core_bus.accept = 1'b1;
      @(negedge clk);
      core_bus.accept = 1'b0;
      #1;
      check({name, " wr dropped"}, core_bus.wr, 16'h0);
      check({name, " id bumped"},  core_bus.req_id, exp_id + 16'd1);
      core_bus.ack     = 1'b1;
      core_bus.error   = err;
      core_bus.resp_id = exp_id + id_off;
      @(negedge clk);
      core_bus.ack   = 1'b0;
      core_bus.error = 1'b0;
      exp_id++;
   endtask

   task automatic core_read_txn(input string name, input logic [31:0] exp_addr,
                                input logic [127:0] line, input logic err,
                                input logic [15:0] id_off, input logic [31:0] exp_rdata,
                                input logic exp_err);
      int n = 0;
      #1;
      while (!core_bus.rd && n < 300) begin
         @(negedge clk); #1; n++;
      end
      check({name, " rd"},      core_bus.rd, 1'b1);
      check({name, " rd addr"}, core_bus.addr, exp_addr);
      check({name, " rd id"},   core_bus.req_id, exp_id);
      core_bus.accept = 1'b1;
      @(negedge clk);
      core_bus.accept    = 1'b0;
      core_bus.ack       = 1'b1;
      core_bus.error     = err;
      core_bus.resp_id   = exp_id + id_off;
      core_bus.read_data = line;
      @(negedge clk);
      core_bus.ack   = 1'b0;
      core_bus.error = 1'b0;
      #1;
      check({name, " resp_valid"}, req_bus.resp_valid, 1'b1);
      check({name, " rdata"},      req_bus.resp_rdata, exp_rdata);
      check({name, " resp_error"}, req_bus.resp_error, exp_err);
      exp_id++;
      @(negedge clk); #1;
      check({name, " resp one cycle"}, req_bus.resp_valid, 1'b0);
   endtask

   initial begin
      int cyc;

      vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 16'h000F, 32'h0000_0010,
                  128'h00000000_00000000_00000000_DEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 32'h0000_0038, 32'hA5A5_A5A5, 4'b0101, 16'h0500, 32'h0000_0030,
                  128'h00000000_00A500A5_00000000_00000000, 32'h0};
      vecs[2] = '{1'b1, 32'h0000_007C, 32'h1122_3344, 4'b1000, 16'h8000, 32'h0000_0070,
                  128'h11000000_00000000_00000000_00000000, 32'h0};
      vecs[3] = '{1'b0, 32'h0000_0208, 32'h0, 4'h0, 16'h0, 32'h0000_0200,
                  128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 32'hCCCC_0002};
      vecs[4] = '{1'b0, 32'h0000_030C, 32'h0, 4'h0, 16'h0, 32'h0000_0300,
                  128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 32'hDDDD_0003};
      vecs[5] = '{1'b0, 32'h0000_0300, 32'h0, 4'h0, 16'h0, 32'h0000_0300,
                  128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 32'hAAAA_0000};
      vecs[6] = '{1'b0, 32'h0000_0307, 32'h0, 4'h0, 16'h0, 32'h0000_0300,
                  128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 32'hBBBB_0001};

      req_bus.req_valid   = 1'b0;
      req_bus.req_we      = 1'b0;
      req_bus.req_addr    = '0;
      req_bus.req_wdata   = '0;
      req_bus.req_be      = '0;
      core_bus.accept     = 1'b0;
      core_bus.ack        = 1'b0;
      core_bus.error      = 1'b0;
      core_bus.resp_id    = '0;
      core_bus.read_data  = '0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single write left alone until the idle timeout flushes it
      req_start(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
      req_wait_accept("timeout wr");
      check("buffered not idle", idle, 1'b0);
      cyc = 0;
      while (core_bus.wr == 16'h0 && cyc < 300) begin
         @(negedge clk); cyc++;
      end
      check("timeout cycles", cyc, 64);
      core_write_txn("timeout", 16'h000F, 32'h0000_0010,
                     128'h00000000_00000000_00000000_DEADBEEF, 1'b0, 16'h0);
      #1;
      check("idle after flush", idle, 1'b1);

      // Table of single transactions
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].we) begin
            req_start(1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            req_wait_accept($sformatf("vec%0d", i));
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            core_write_txn($sformatf("vec%0d", i), vecs[i].exp_mask, vecs[i].exp_addr,
                           vecs[i].line, 1'b0, 16'h0);
         end else begin
            req_start(1'b0, vecs[i].addr, 32'h0, 4'h0);
            req_wait_accept($sformatf("vec%0d", i));
            core_read_txn($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].line,
                          1'b0, 16'h0, vecs[i].exp_rdata, 1'b0);
         end
      end

      // Four word writes fill the line and flush at once, exactly once
      for (int w = 0; w < 4; w++) begin
         req_start(1'b1, 32'h0000_0020 + 32'(4*w), {4{8'(8'h11 * (w + 1))}}, 4'hF);
         req_wait_accept("full wr");
      end
      cyc = 0;
      while (core_bus.wr == 16'h0 && cyc < 300) begin
         @(negedge clk); cyc++;
      end
      check("full flush latency", cyc <= 2, 1'b1);
      core_write_txn("full", 16'hFFFF, 32'h0000_0020,
                     128'h44444444_33333333_22222222_11111111, 1'b0, 16'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("full single flush", core_bus.wr, 16'h0);
      end

      // Write to a new line waits for the old line's flush to finish
      req_start(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF);
      req_wait_accept("line A");
      req_start(1'b1, 32'h0000_0050, 32'h5566_7788, 4'hF);
      #1;
      check("line B blocked", req_bus.req_ready, 1'b0);
      cyc = 0;
      while (core_bus.wr == 16'h0 && cyc < 300) begin
         @(negedge clk); #1; cyc++;
      end
      check("line A mask", core_bus.wr, 16'h000F);
      check("line A addr", core_bus.addr, 32'h0000_0040);
      check("line A data", core_bus.write_data, 128'h0BADF00D);
      check("blocked in flush req", req_bus.req_ready, 1'b0);
      core_bus.accept = 1'b1;
      @(negedge clk);
      core_bus.accept = 1'b0;
      #1;
      check("blocked in flush ack", req_bus.req_ready, 1'b0);
      core_bus.ack     = 1'b1;
      core_bus.resp_id = exp_id;
      @(negedge clk);
      core_bus.ack = 1'b0;
      exp_id++;
      #1;
      check("line B ready after ack", req_bus.req_ready, 1'b1);
      @(negedge clk);
      req_bus.req_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      core_write_txn("line B", 16'h000F, 32'h0000_0050, 128'h55667788, 1'b0, 16'h0);

      // Read after write to the same line: flush comes first
      req_start(1'b1, 32'h0000_0104, 32'hAAAA_5555, 4'hF);
      req_wait_accept("raw wr");
      req_start(1'b0, 32'h0000_0104, 32'h0, 4'h0);
      #1;
      check("raw read blocked", req_bus.req_ready, 1'b0);
      core_write_txn("raw flush", 16'h00F0, 32'h0000_0100,
                     128'h00000000_00000000_AAAA5555_00000000, 1'b0, 16'h0);
      req_wait_accept("raw rd");
      core_read_txn("raw rd", 32'h0000_0100, 128'h33333333_22222222_12345678_00000000,
                    1'b0, 16'h0, 32'h1234_5678, 1'b0);

      // flush_i with nothing buffered does nothing
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("empty flush no wr", core_bus.wr, 16'h0);
         check("empty flush idle", idle, 1'b1);
      end

      // Byte merge: overwrite one byte, a be=0 write changes nothing
      req_start(1'b1, 32'h0000_0060, 32'h0102_0304, 4'hF);
      req_wait_accept("merge 1");
      req_start(1'b1, 32'h0000_0060, 32'hFFFF_FFFF, 4'h0);
      req_wait_accept("merge 2");
      req_start(1'b1, 32'h0000_0061, 32'h0000_AB00, 4'b0010);
      req_wait_accept("merge 3");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      core_write_txn("merge", 16'h000F, 32'h0000_0060, 128'h0102AB04, 1'b0, 16'h0);

      // Error reporting
      #1;
      check("wr_err clear", wr_err, 1'b0);
      req_start(1'b0, 32'h0000_0500, 32'h0, 4'h0);
      req_wait_accept("rd err");
      core_read_txn("rd err", 32'h0000_0500, 128'h0000000F_0000000E_0000000D_0E0E0E0E,
                    1'b1, 16'h0, 32'h0E0E_0E0E, 1'b1);
      req_start(1'b0, 32'h0000_0504, 32'h0, 4'h0);
      req_wait_accept("rd idmiss");
      core_read_txn("rd idmiss", 32'h0000_0500, 128'h0000000F_0000000E_0000000D_0E0E0E0E,
                    1'b0, 16'h1, 32'h0000_000D, 1'b1);
      req_start(1'b1, 32'h0000_0600, 32'h600D_0001, 4'hF);
      req_wait_accept("wr err");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      core_write_txn("wr err", 16'h000F, 32'h0000_0600, 128'h600D0001, 1'b1, 16'h0);
      #1;
      check("wr_err set", wr_err, 1'b1);
      req_start(1'b1, 32'h0000_0610, 32'h600D_0002, 4'hF);
      req_wait_accept("wr ok");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      core_write_txn("wr ok", 16'h000F, 32'h0000_0610, 128'h600D0002, 1'b0, 16'h0);
      #1;
      check("wr_err sticky", wr_err, 1'b1);

      // Reset while waiting for a read ack
      req_start(1'b0, 32'h0000_0400, 32'h0, 4'h0);
      req_wait_accept("rst rd");
      #1;
      check("rst rd issued", core_bus.rd, 1'b1);
      core_bus.accept = 1'b1;
      @(negedge clk);
      core_bus.accept = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid reset");
      exp_id = 16'h0000;
      @(negedge clk);
      core_bus.ack       = 1'b1;
      core_bus.resp_id   = 16'h0011;
      core_bus.read_data = 128'hFFFF;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         core_bus.ack = 1'b0;
         #1;
         check("no resp after reset", req_bus.resp_valid, 1'b0);
      end
      req_start(1'b1, 32'h0000_0700, 32'h7777_7777, 4'hF);
      req_wait_accept("post reset wr");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      core_write_txn("post reset", 16'h000F, 32'h0000_0700, 128'h77777777, 1'b0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
